// File: rtl/nn_train_ctrl.sv
// Command sequencer between a host front-end and the neural network datapath.
// Define NN_TRAIN_CTRL_STATS_EN to add the stat_trains / stat_correct counters.
module nn_train_ctrl #(
    parameter int NUM_WIDTH   = 16,
    parameter int IN_SIZE     = 4,
    parameter int OUT_SIZE    = 4,
    parameter int INDEX_WIDTH = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [1:0]                    cmd_layer,
    input  logic [INDEX_WIDTH-1:0]        cmd_i,
    input  logic [INDEX_WIDTH-1:0]        cmd_j,
    input  logic [NUM_WIDTH-1:0]          cmd_wdata,
    input  logic [IN_SIZE*NUM_WIDTH-1:0]  cmd_x,
    input  logic [OUT_SIZE*NUM_WIDTH-1:0] cmd_y,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [OUT_SIZE*NUM_WIDTH-1:0] rsp_data,
    output logic [NUM_WIDTH-1:0]          rsp_rdata,
    output logic                          rsp_err,
    output logic                          busy,
    output logic                          nn_fp,
    output logic                          nn_bp,
    output logic                          nn_wu,
    input  logic                          nn_fp_out,
    input  logic                          nn_bp_out,
    output logic [IN_SIZE*NUM_WIDTH-1:0]  nn_a0,
    output logic [OUT_SIZE*NUM_WIDTH-1:0] nn_g3,
    input  logic [OUT_SIZE*NUM_WIDTH-1:0] nn_a3,
    output logic [1:0]                    nn_w_layer,
    output logic [INDEX_WIDTH-1:0]        nn_w_i,
    output logic [INDEX_WIDTH-1:0]        nn_w_j,
    output logic [NUM_WIDTH-1:0]          nn_w_in,
    input  logic [NUM_WIDTH-1:0]          nn_w_out
`ifdef NN_TRAIN_CTRL_STATS_EN
    ,
    output logic [15:0]                   stat_trains,
    output logic [15:0]                   stat_correct
`endif
);

    typedef enum logic [2:0] {IDLE, FWD_WAIT, BWD_WAIT, WR, RD, RESP} state_t;

    localparam logic [1:0]  OP_INFER = 2'd0;
    localparam logic [1:0]  OP_TRAIN = 2'd1;
    localparam logic [1:0]  OP_WRITE = 2'd2;
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t                        state;
    logic [1:0]                    op_r;
    logic [1:0]                    layer_r;
    logic [INDEX_WIDTH-1:0]        i_r;
    logic [INDEX_WIDTH-1:0]        j_r;
    logic [NUM_WIDTH-1:0]          wdata_r;
    logic [IN_SIZE*NUM_WIDTH-1:0]  x_r;
    logic [OUT_SIZE*NUM_WIDTH-1:0] y_r;
    logic [15:0]                   wait_cnt;

    assign nn_a0      = x_r;
    assign nn_g3      = y_r;
    assign nn_w_layer = layer_r;
    assign nn_w_i     = i_r;
    assign nn_w_j     = j_r;
    assign nn_w_in    = wdata_r;

`ifdef NN_TRAIN_CTRL_STATS_EN
    // Signed argmax; strict compare keeps the lowest index on ties.
    function automatic logic [7:0] argmax(input logic [OUT_SIZE*NUM_WIDTH-1:0] v);
        logic [7:0]                  idx;
        logic signed [NUM_WIDTH-1:0] best;
        idx  = '0;
        best = $signed(v[NUM_WIDTH-1:0]);
        for (int k = 1; k < OUT_SIZE; k++) begin
            if ($signed(v[k*NUM_WIDTH +: NUM_WIDTH]) > best) begin
                best = $signed(v[k*NUM_WIDTH +: NUM_WIDTH]);
                idx  = 8'(k);
            end
        end
        return idx;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_r      <= '0;
            layer_r   <= '0;
            i_r       <= '0;
            j_r       <= '0;
            wdata_r   <= '0;
            x_r       <= '0;
            y_r       <= '0;
            wait_cnt  <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            nn_fp     <= 1'b0;
            nn_bp     <= 1'b0;
            nn_wu     <= 1'b0;
`ifdef NN_TRAIN_CTRL_STATS_EN
            stat_trains  <= '0;
            stat_correct <= '0;
`endif
        end else begin
            nn_fp <= 1'b0;
            nn_bp <= 1'b0;
            nn_wu <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        op_r      <= cmd_op;
                        layer_r   <= cmd_layer;
                        i_r       <= cmd_i;
                        j_r       <= cmd_j;
                        wdata_r   <= cmd_wdata;
                        x_r       <= cmd_x;
                        y_r       <= cmd_y;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        wait_cnt  <= '0;
                        if (cmd_op == OP_INFER || cmd_op == OP_TRAIN) begin
                            state <= FWD_WAIT;
                            nn_fp <= 1'b1;
                        end else if (cmd_layer == 2'd3) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (cmd_op == OP_WRITE) begin
                            state <= WR;
                            nn_wu <= 1'b1;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                // nn_fp is still high in the first wait cycle, which masks nn_fp_out there.
                FWD_WAIT: begin
                    if (!nn_fp && nn_fp_out) begin
                        rsp_data <= nn_a3;
                        wait_cnt <= '0;
                        if (op_r == OP_TRAIN) begin
                            state <= BWD_WAIT;
                            nn_bp <= 1'b1;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                BWD_WAIT: begin
                    if (nn_bp_out) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
`ifdef NN_TRAIN_CTRL_STATS_EN
                        if (stat_trains != 16'hFFFF)
                            stat_trains <= stat_trains + 16'd1;
                        if (argmax(rsp_data) == argmax(y_r) && stat_correct != 16'hFFFF)
                            stat_correct <= stat_correct + 16'd1;
`endif
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                WR: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end
                RD: begin
                    rsp_rdata <= nn_w_out;
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_train_ctrl.sv
// Directed testbench for nn_train_ctrl with a small behavioural network model.
// Stats checks are compiled in when NN_TRAIN_CTRL_STATS_EN is defined.
module tb_nn_train_ctrl;

    localparam int NW = 16;
    localparam int IS = 4;
    localparam int OS = 4;
    localparam int IW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = '0;
    logic [1:0]       cmd_layer = '0;
    logic [IW-1:0]    cmd_i = '0;
    logic [IW-1:0]    cmd_j = '0;
    logic [NW-1:0]    cmd_wdata = '0;
    logic [IS*NW-1:0] cmd_x = '0;
    logic [OS*NW-1:0] cmd_y = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [OS*NW-1:0] rsp_data;
    logic [NW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic             busy;
    logic             nn_fp, nn_bp, nn_wu;
    logic             nn_fp_out = 1'b0;
    logic             nn_bp_out = 1'b0;
    logic [IS*NW-1:0] nn_a0;
    logic [OS*NW-1:0] nn_g3;
    logic [OS*NW-1:0] nn_a3 = '0;
    logic [1:0]       nn_w_layer;
    logic [IW-1:0]    nn_w_i, nn_w_j;
    logic [NW-1:0]    nn_w_in;
    logic [NW-1:0]    nn_w_out;
`ifdef NN_TRAIN_CTRL_STATS_EN
    logic [15:0]      stat_trains, stat_correct;
`endif

    nn_train_ctrl #(.NUM_WIDTH(NW), .IN_SIZE(IS), .OUT_SIZE(OS),
                    .INDEX_WIDTH(IW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_layer(cmd_layer), .cmd_i(cmd_i), .cmd_j(cmd_j),
        .cmd_wdata(cmd_wdata), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .nn_fp(nn_fp), .nn_bp(nn_bp), .nn_wu(nn_wu),
        .nn_fp_out(nn_fp_out), .nn_bp_out(nn_bp_out),
        .nn_a0(nn_a0), .nn_g3(nn_g3), .nn_a3(nn_a3),
        .nn_w_layer(nn_w_layer), .nn_w_i(nn_w_i), .nn_w_j(nn_w_j),
        .nn_w_in(nn_w_in), .nn_w_out(nn_w_out)
`ifdef NN_TRAIN_CTRL_STATS_EN
        , .stat_trains(stat_trains), .stat_correct(stat_correct)
`endif
    );

    // Network model knobs, set by the stimulus process
    int               fp_lat = 0;
    int               bp_lat = 0;
    logic [OS*NW-1:0] model_a3 = '0;
    logic [OS*NW-1:0] watch_g3 = '0;
    logic             g3_watch = 1'b0;

    // Network model state and observations
    int            cyc = 0;
    int            fp_cnt = 0, bp_cnt = 0;
    int            fp_pulses = 0, bp_pulses = 0, wu_pulses = 0;
    int            fp_out_cyc = 0, bp_cyc = 0, g3_errs = 0;
    logic [NW-1:0] wu_data = '0;
    logic [NW-1:0] wmem [0:1023] = '{default: '0};

    assign nn_w_out = wmem[{nn_w_layer, nn_w_i, nn_w_j}];

    always @(posedge clk) cyc++;

    // nn_a3 only carries the real result during the completion pulse.
    always @(negedge clk) begin
        nn_fp_out = 1'b0;
        nn_bp_out = 1'b0;
        nn_a3     = ~model_a3;
        if (fp_cnt > 0) begin
            fp_cnt--;
            if (fp_cnt == 0) begin
                nn_fp_out  = 1'b1;
                nn_a3      = model_a3;
                fp_out_cyc = cyc;
            end
        end
        if (bp_cnt > 0) begin
            bp_cnt--;
            if (bp_cnt == 0) nn_bp_out = 1'b1;
        end
        if (nn_fp) begin
            fp_pulses++;
            if (fp_lat > 0) fp_cnt = fp_lat;
        end
        if (nn_bp) begin
            bp_pulses++;
            bp_cyc = cyc;
            if (bp_lat > 0) bp_cnt = bp_lat;
        end
        if (nn_wu) begin
            wu_pulses++;
            wu_data = nn_w_in;
            wmem[{nn_w_layer, nn_w_i, nn_w_j}] = nn_w_in;
        end
        if (g3_watch && busy && nn_g3 !== watch_g3) g3_errs++;
    end

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] layer,
                                 input logic [IW-1:0] wi, input logic [IW-1:0] wj,
                                 input logic [NW-1:0] wd, input logic [IS*NW-1:0] x,
                                 input logic [OS*NW-1:0] y);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("cmd_ready_before_accept", {63'd0, cmd_ready}, 64'd1);
        cmd_op    = op;
        cmd_layer = layer;
        cmd_i     = wi;
        cmd_j     = wj;
        cmd_wdata = wd;
        cmd_x     = x;
        cmd_y     = y;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // lat = number of cycles from the accept cycle to the first RESP cycle
    task automatic waitResp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("rsp_valid_arrives", {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic finishResp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checkOutput("cmd_ready_after_resp", {63'd0, cmd_ready}, 64'd1);
        checkOutput("busy_after_resp", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int   lat;
        int   fp_before;
        logic quiet;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("reset_rsp_data", rsp_data, 64'd0);
        checkOutput("reset_nn_fp", {63'd0, nn_fp}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // Infer, 5-cycle forward latency
        fp_lat   = 5;
        model_a3 = 64'h0040_0030_0020_0010;
        applyStimulus(2'd0, 2'd0, '0, '0, '0, 64'h0004_0003_0002_0001, 64'd0);
        checkOutput("infer_fp_pulse", {63'd0, nn_fp}, 64'd1);
        checkOutput("infer_a0", nn_a0, 64'h0004_0003_0002_0001);
        waitResp(lat);
        checkOutput("infer_latency", 64'(lat), 64'd7);
        checkOutput("infer_rsp_data", rsp_data, 64'h0040_0030_0020_0010);
        checkOutput("infer_rsp_err", {63'd0, rsp_err}, 64'd0);
        checkOutput("infer_fp_count", 64'(fp_pulses), 64'd1);
        checkOutput("infer_bp_count", 64'(bp_pulses), 64'd0);
        finishResp();

        // Train: bp completion lands exactly on the last timeout cycle
        fp_lat   = 3;
        bp_lat   = 7;
        model_a3 = 64'h0005_0100_0007_0003;
        watch_g3 = 64'h0011_0022_0033_0044;
        g3_watch = 1'b1;
        applyStimulus(2'd1, 2'd0, '0, '0, '0, 64'h0008_0007_0006_0005, 64'h0011_0022_0033_0044);
        waitResp(lat);
        g3_watch = 1'b0;
        checkOutput("train_latency", 64'(lat), 64'd13);
        checkOutput("train_bp_after_capture", 64'(bp_cyc - fp_out_cyc), 64'd1);
        checkOutput("train_bp_count", 64'(bp_pulses), 64'd1);
        checkOutput("train_g3_stable", 64'(g3_errs), 64'd0);
        checkOutput("train_rsp_err", {63'd0, rsp_err}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checkOutput("train_stall_valid", {63'd0, rsp_valid}, 64'd1);
            checkOutput("train_stall_data", rsp_data, 64'h0005_0100_0007_0003);
        end
        finishResp();

        // Weight write then read back, then illegal layer read
        applyStimulus(2'd2, 2'd2, 4'd3, 4'd1, 16'h1234, 64'd0, 64'd0);
        waitResp(lat);
        checkOutput("write_latency", 64'(lat), 64'd2);
        checkOutput("write_wu_count", 64'(wu_pulses), 64'd1);
        checkOutput("write_wu_data", 64'(wu_data), 64'h1234);
        checkOutput("write_rsp_err", {63'd0, rsp_err}, 64'd0);
        finishResp();
        applyStimulus(2'd3, 2'd2, 4'd3, 4'd1, 16'h0, 64'd0, 64'd0);
        waitResp(lat);
        checkOutput("read_latency", 64'(lat), 64'd2);
        checkOutput("read_rdata", 64'(rsp_rdata), 64'h1234);
        checkOutput("read_no_wu", 64'(wu_pulses), 64'd1);
        finishResp();
        applyStimulus(2'd3, 2'd3, 4'd3, 4'd1, 16'h0, 64'd0, 64'd0);
        waitResp(lat);
        checkOutput("badlayer_latency", 64'(lat), 64'd1);
        checkOutput("badlayer_rsp_err", {63'd0, rsp_err}, 64'd1);
        checkOutput("badlayer_rdata_cleared", 64'(rsp_rdata), 64'd0);
        checkOutput("badlayer_no_wu", 64'(wu_pulses), 64'd1);
        finishResp();

        // Silent network: timeout keeps the previous rsp_data
        fp_lat   = 0;
        model_a3 = 64'h7777_6666_5555_4444;
        applyStimulus(2'd0, 2'd0, '0, '0, '0, 64'd1, 64'd0);
        waitResp(lat);
        checkOutput("timeout_latency", 64'(lat), 64'd9);
        checkOutput("timeout_rsp_err", {63'd0, rsp_err}, 64'd1);
        checkOutput("timeout_rsp_data_kept", rsp_data, 64'h0005_0100_0007_0003);
        finishResp();

        // Minimum turnaround after a timeout
        fp_lat = 1;
        applyStimulus(2'd0, 2'd0, '0, '0, '0, 64'd2, 64'd0);
        waitResp(lat);
        checkOutput("fast_latency", 64'(lat), 64'd3);
        checkOutput("fast_rsp_err", {63'd0, rsp_err}, 64'd0);
        checkOutput("fast_rsp_data", rsp_data, 64'h7777_6666_5555_4444);
        finishResp();

        // Reset in the middle of FWD_WAIT; the late nn_fp_out must be ignored
        fp_lat = 6;
        applyStimulus(2'd0, 2'd0, '0, '0, '0, 64'd3, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        fp_before = fp_pulses;
        @(posedge clk); #1;
        checkOutput("midreset_busy", {63'd0, busy}, 64'd0);
        checkOutput("midreset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        quiet = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (busy || rsp_valid || nn_fp || nn_bp) quiet = 1'b0;
        end
        checkOutput("midreset_quiet", {63'd0, quiet}, 64'd1);
        checkOutput("midreset_no_fp", 64'(fp_pulses - fp_before), 64'd0);

`ifdef NN_TRAIN_CTRL_STATS_EN
        checkOutput("stats_reset_trains", 64'(stat_trains), 64'd0);
        checkOutput("stats_reset_correct", 64'(stat_correct), 64'd0);
        fp_lat = 2;
        bp_lat = 2;
        model_a3 = 64'h0001_0009_0002_0003;
        applyStimulus(2'd1, 2'd0, '0, '0, '0, 64'd0, 64'h0000_0007_0000_0000);
        waitResp(lat);
        finishResp();
        model_a3 = 64'h0004_0004_0001_0004;
        applyStimulus(2'd1, 2'd0, '0, '0, '0, 64'd0, 64'h0002_0002_0002_0002);
        waitResp(lat);
        finishResp();
        model_a3 = 64'h0003_0002_FFFE_0001;
        applyStimulus(2'd1, 2'd0, '0, '0, '0, 64'd0, 64'h0000_0000_0005_0000);
        waitResp(lat);
        finishResp();
        checkOutput("stats_trains", 64'(stat_trains), 64'd3);
        checkOutput("stats_correct", 64'(stat_correct), 64'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
